io_pipelined_interconnect: RTL and testbench

// - Next-generation IO interconnect. Arbitrates IO requests from NUM_REQUESTERS cores onto one external IO bus.
// - Unlike the single-cycle interconnect, the bus has a valid/ready request handshake and variable response latency.
// - Up to MAX_OUTSTANDING requests may be in flight. Their tags {core, thread} are held in an in-order tag FIFO.
// - Sits between the per-core IO request queues and the SoC IO fabric.
//

---
 rtl/io_pipelined_interconnect.sv | 157 +++++++++++++++
 tb/tb_io_pipelined_interconnect.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pipelined_interconnect.sv
// Round-robin IO arbiter onto a valid/ready bus with an in-order {core, thread} tag FIFO.
// Define IO_PERF_COUNTERS_EN to add the perf_io_requests / perf_io_stall_cycles outputs.
module io_pipelined_interconnect #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_IDX_WIDTH = 2,
    parameter int MAX_OUTSTANDING  = 4,
    localparam int CORE_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQUESTERS-1:0]                ior_request_valid,
    input  logic [NUM_REQUESTERS-1:0]                ior_is_store,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]     ior_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]     ior_value,
    input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0] ior_thread_idx,
    output logic [NUM_REQUESTERS-1:0]                ii_ready,
    output logic                                     ii_response_valid,
    output logic [CORE_W-1:0]                        ii_response_core,
    output logic [THREAD_IDX_WIDTH-1:0]              ii_response_thread_idx,
    output logic [DATA_WIDTH-1:0]                    ii_response_read_value,
    output logic                                     io_req_valid,
    input  logic                                     io_req_ready,
    output logic                                     io_req_is_store,
    output logic [ADDR_WIDTH-1:0]                    io_req_address,
    output logic [DATA_WIDTH-1:0]                    io_req_write_data,
    input  logic                                     io_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                    io_rsp_read_data
`ifdef IO_PERF_COUNTERS_EN
    ,
    output logic [31:0]                              perf_io_requests,
    output logic [31:0]                              perf_io_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = CORE_W + THREAD_IDX_WIDTH;

    logic [CORE_W-1:0]           arb_ptr_q, arb_ptr_d;
    logic [CORE_W-1:0]           grant;
    logic [CORE_W-1:0]           cand;
    logic                        found;
    logic                        accept;
    logic                        fifo_full, fifo_empty, pop;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [TAG_W-1:0]            tag_mem_q [MAX_OUTSTANDING];
    logic [TAG_W-1:0]            head_tag;
    logic [THREAD_IDX_WIDTH-1:0] grant_thread;
    logic                        rsp_valid_q;
    logic [CORE_W-1:0]           rsp_core_q;
    logic [THREAD_IDX_WIDTH-1:0] rsp_thread_q;
    logic [DATA_WIDTH-1:0]       rsp_data_q;

    // Grant ignores io_req_ready so the bus may derive ready from valid.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = CORE_W'((int'(arb_ptr_q) + i) % NUM_REQUESTERS);
            if (!found && ior_request_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign pop        = io_rsp_valid && !fifo_empty;
    assign head_tag   = tag_mem_q[rd_ptr_q];

    assign io_req_valid      = (|ior_request_valid) && !fifo_full;
    assign accept            = io_req_valid && io_req_ready;
    assign io_req_is_store   = ior_is_store[grant];
    assign io_req_address    = ior_address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign io_req_write_data = ior_value[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_thread      = ior_thread_idx[int'(grant)*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];

    always_comb begin
        ii_ready        = '0;
        ii_ready[grant] = accept;
    end

    always_comb begin
        arb_ptr_d = arb_ptr_q;
        if (accept) begin
            if (int'(grant) == NUM_REQUESTERS - 1) arb_ptr_d = '0;
            else arb_ptr_d = grant + CORE_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept && !pop) count_d = count_q + CNT_W'(1);
        else if (!accept && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_ptr_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            arb_ptr_q   <= arb_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= pop;
            if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Tag storage and response payload carry no reset.
    always_ff @(posedge clk) begin
        if (accept) tag_mem_q[wr_ptr_q] <= {grant, grant_thread};
        if (pop) begin
            rsp_core_q   <= head_tag[TAG_W-1 -: CORE_W];
            rsp_thread_q <= head_tag[THREAD_IDX_WIDTH-1:0];
            rsp_data_q   <= io_rsp_read_data;
        end
    end

    assign ii_response_valid      = rsp_valid_q;
    assign ii_response_core       = (NUM_REQUESTERS == 1) ? '0 : rsp_core_q;
    assign ii_response_thread_idx = rsp_thread_q;
    assign ii_response_read_value = rsp_data_q;

`ifdef IO_PERF_COUNTERS_EN
    logic [31:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept) perf_req_q <= perf_req_q + 32'd1;
            if ((|ior_request_valid) && !accept) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_io_requests     = perf_req_q;
    assign perf_io_stall_cycles = perf_stall_q;
`endif

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(io_rsp_valid && fifo_empty))
                else $warning("io_rsp_valid with empty tag FIFO; response dropped");
        end
    end

endmodule

// File: tb/tb_io_pipelined_interconnect.sv
// Directed bench for io_pipelined_interconnect: latency, fairness, backpressure,
// full FIFO, response ordering and reset behaviour.
module tb_io_pipelined_interconnect;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    rv, st;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] val;
    logic [N*TW-1:0] thr;
    logic [N-1:0]    ii_ready;
    logic            rsp_v;
    logic [1:0]      rsp_core;
    logic [TW-1:0]   rsp_thr;
    logic [DW-1:0]   rsp_data;
    logic            req_v, req_rdy, req_st;
    logic [AW-1:0]   req_a;
    logic [DW-1:0]   req_wd;
    logic            bus_rsp_v;
    logic [DW-1:0]   bus_rsp_d;
`ifdef IO_PERF_COUNTERS_EN
    logic [31:0]     perf_req, perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    io_pipelined_interconnect dut (
        .clk                    (clk),
        .reset                  (reset),
        .ior_request_valid      (rv),
        .ior_is_store           (st),
        .ior_address            (addr),
        .ior_value              (val),
        .ior_thread_idx         (thr),
        .ii_ready               (ii_ready),
        .ii_response_valid      (rsp_v),
        .ii_response_core       (rsp_core),
        .ii_response_thread_idx (rsp_thr),
        .ii_response_read_value (rsp_data),
        .io_req_valid           (req_v),
        .io_req_ready           (req_rdy),
        .io_req_is_store        (req_st),
        .io_req_address         (req_a),
        .io_req_write_data      (req_wd),
        .io_rsp_valid           (bus_rsp_v),
        .io_rsp_read_data       (bus_rsp_d)
`ifdef IO_PERF_COUNTERS_EN
        ,
        .perf_io_requests       (perf_req),
        .perf_io_stall_cycles   (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_req();
        rv   = '0;
        st   = '0;
        addr = '0;
        val  = '0;
        thr  = '0;
    endtask

    task automatic req(input int c, input logic s, input logic [TW-1:0] t,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        rv[c]           = 1'b1;
        st[c]           = s;
        thr[c*TW +: TW] = t;
        addr[c*AW +: AW] = a;
        val[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        clr_req();
        reset     = 1'b1;
        req_rdy   = 1'b0;
        bus_rsp_v = 1'b0;
        bus_rsp_d = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cores [4];
        logic [TW-1:0] thrs [4];
        logic [N-1:0] onehot;
        cores = '{3, 0, 2, 1};
        thrs  = '{2'd2, 2'd1, 2'd3, 2'd0};

        // Reset state
        do_reset();
        settle();
        chk("rst_rsp_valid", rsp_v, 0);
        chk("rst_ii_ready", ii_ready, 0);
        chk("rst_req_valid_idle", req_v, 0);
        req(1, 1'b0, 2'd0, 32'h10, 32'h0);
        settle();
        chk("rst_req_valid_follows", req_v, 1);
        chk("rst_ii_ready_noready", ii_ready, 0);

        // Single load: core 2 thread 1, rsp the next cycle
        clr_req();
        req(2, 1'b0, 2'd1, 32'h100, 32'h0);
        req_rdy = 1'b1;
        settle();
        chk("t1_ii_ready", ii_ready, 4'b0100);
        chk("t1_req_addr", req_a, 32'h100);
        chk("t1_req_store", req_st, 0);
        tick();
        clr_req();
        req_rdy   = 1'b0;
        bus_rsp_v = 1'b1;
        bus_rsp_d = 32'hCAFE;
        settle();
        chk("t1_rsp_early", rsp_v, 0);
        tick();
        bus_rsp_v = 1'b0;
        settle();
        chk("t1_rsp_valid", rsp_v, 1);
        chk("t1_rsp_core", rsp_core, 2);
        chk("t1_rsp_thr", rsp_thr, 1);
        chk("t1_rsp_data", rsp_data, 32'hCAFE);
        tick();
        chk("t1_rsp_once", rsp_v, 0);

        // Fairness: all cores requesting, one rsp per cycle keeps FIFO draining
        do_reset();
        for (int c = 0; c < N; c++) req(c, 1'b0, TW'(c), AW'(32'h200 + c), '0);
        req_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_rsp_v = (i > 0);
            bus_rsp_d = DW'(i);
            settle();
            onehot = N'(1 << (i % 4));
            chk("t2_grant", ii_ready, onehot);
            chk("t2_rsp_valid", rsp_v, (i >= 2));
            if (i >= 2) begin
                chk("t2_rsp_core", rsp_core, (i - 2) % 4);
                chk("t2_rsp_data", rsp_data, i - 1);
            end
            tick();
        end

        // Backpressure: core 1 held off for 5 cycles
        do_reset();
        req(1, 1'b0, 2'd3, 32'h300, '0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_stall_ready", ii_ready, 0);
            chk("t3_stall_valid", req_v, 1);
            tick();
        end
        req_rdy = 1'b1;
        settle();
        chk("t3_grant", ii_ready, 4'b0010);
        chk("t3_addr", req_a, 32'h300);
        tick();
        clr_req();
        req_rdy = 1'b0;
`ifdef IO_PERF_COUNTERS_EN
        settle();
        chk("t3_perf_req", perf_req, 1);
        chk("t3_perf_stall", perf_stall, 5);
`endif

        // Full FIFO blocks requests; a same-cycle pop frees one slot next cycle
        do_reset();
        req(0, 1'b0, 2'd0, 32'h40, '0);
        req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t4_fill", ii_ready, 4'b0001);
            tick();
        end
        bus_rsp_v = 1'b1;
        bus_rsp_d = 32'h77;
        settle();
        chk("t4_full_valid", req_v, 0);
        chk("t4_full_ready", ii_ready, 0);
        tick();
        bus_rsp_v = 1'b0;
        settle();
        chk("t4_after_pop_valid", req_v, 1);
        chk("t4_after_pop_ready", ii_ready, 4'b0001);
        chk("t4_rsp_valid", rsp_v, 1);
        chk("t4_rsp_data", rsp_data, 32'h77);
        tick();
        clr_req();
        req_rdy = 1'b0;

        // Ordering: cores 3,0,2,1 outstanding, responses 1..4
        do_reset();
        req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clr_req();
            req(cores[i], (cores[i] == 2), thrs[i], AW'(32'h1000 + cores[i]),
                DW'(32'h5A00 + cores[i]));
            settle();
            onehot = N'(1 << cores[i]);
            chk("t5_grant", ii_ready, onehot);
            chk("t5_store", req_st, (cores[i] == 2));
            chk("t5_wdata", req_wd, 32'h5A00 + cores[i]);
            tick();
        end
        clr_req();
        req_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rsp_v = (i < 4);
            bus_rsp_d = DW'(i + 1);
            settle();
            if (i > 0) begin
                chk("t5_rsp_valid", rsp_v, 1);
                chk("t5_rsp_core", rsp_core, cores[i-1]);
                chk("t5_rsp_thr", rsp_thr, thrs[i-1]);
                chk("t5_rsp_data", rsp_data, i);
            end
            tick();
        end
        bus_rsp_v = 1'b0;
        settle();
        chk("t5_rsp_done", rsp_v, 0);

        // Reset with 3 in flight, then a stray bus response
        do_reset();
        req(0, 1'b0, 2'd1, 32'h80, '0);
        req_rdy = 1'b1;
        tick();
        tick();
        tick();
        clr_req();
        req_rdy = 1'b0;
        reset   = 1'b1;
        tick();
        reset     = 1'b0;
        bus_rsp_v = 1'b1;
        bus_rsp_d = 32'hDEAD;
        settle();
        tick();
        bus_rsp_v = 1'b0;
        settle();
        chk("t6_no_rsp", rsp_v, 0);
`ifdef IO_PERF_COUNTERS_EN
        chk("t6_perf_req", perf_req, 0);
        chk("t6_perf_stall", perf_stall, 0);
`endif
        req(0, 1'b0, 2'd1, 32'h80, '0);
        req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t6_room", req_v, 1);
            tick();
        end
        settle();
        chk("t6_full_again", req_v, 0);
        clr_req();
        req_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
